layer0_input_encoder: RTL

Streaming front-end that produces the packed 2-bit activation vector consumed by the layer-0 LUT neurons. Raw per-feature samples arrive one per beat over a valid/ready stream. Each sample is quantized against three runtime-programmable thresholds into a 2-bit code. Once a full frame is collected, the block presents one N_FEAT*2-bit vector to the layer-0 fabric under a valid/ready handshake.

---
 rtl/layer0_enc_pkg.sv | 17 +
 rtl/layer0_feat_quant.sv | 21 ++
 rtl/layer0_input_encoder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/layer0_enc_pkg.sv
// Shared constants for the layer-0 input encoder: code geometry, FSM state
// encodings and the reset value of each quantization threshold.
package layer0_enc_pkg;

  localparam int CODE_W = 2;
  localparam int N_THR  = 3;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  // Thresholds split the unsigned sample range into quarters: (k+1)*2^(W-2).
  function automatic logic [31:0] rst_thr(input int feat_w, input int k);
    return 32'((k + 1) << (feat_w - 2));
  endfunction

endpackage

// File: rtl/layer0_feat_quant.sv
// Combinational quantizer: code is the number of thresholds the sample meets
// or exceeds, so non-monotonic threshold sets still give a defined 0..3 code.
module layer0_feat_quant
  import layer0_enc_pkg::*;
#(
  parameter int FEAT_W = 8
) (
  input  logic [FEAT_W-1:0] sample_i,
  input  logic [FEAT_W-1:0] thr0_i,
  input  logic [FEAT_W-1:0] thr1_i,
  input  logic [FEAT_W-1:0] thr2_i,
  output logic [CODE_W-1:0] code_o
);

  always_comb begin
    code_o = CODE_W'(sample_i >= thr0_i)
           + CODE_W'(sample_i >= thr1_i)
           + CODE_W'(sample_i >= thr2_i);
  end

endmodule

// File: rtl/layer0_input_encoder.sv
// Streaming sample quantizer that packs one frame of 2-bit codes into a vector
// for the layer-0 LUT fabric. Define LN_INPUT_STATS_EN for frame/error counters.
module layer0_input_encoder
  import layer0_enc_pkg::*;
#(
  parameter int N_FEAT = 16,
  parameter int FEAT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FEAT_W-1:0]          s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [N_FEAT*CODE_W-1:0]   m_data,
  input  logic                       cfg_we,
  input  logic [$clog2(N_FEAT)-1:0]  cfg_feat,
  input  logic [1:0]                 cfg_sel,
  input  logic [FEAT_W-1:0]          cfg_data,
  output logic                       err_frame,
  output logic [15:0]                frame_cnt,
  output logic [15:0]                err_cnt
);

  localparam int IDX_W = $clog2(N_FEAT);
  localparam int VEC_W = N_FEAT * CODE_W;

  // Handshakes: a sample moves on a rising edge with s_valid && s_ready; a
  // vector moves with m_valid && m_ready, and m_data is held until then.
  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VEC_W-1:0]  shadow_q, shadow_d;
  logic [VEC_W-1:0]  m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              err_q, err_d;
  logic [FEAT_W-1:0] thr_q [N_FEAT][N_THR];
  logic [CODE_W-1:0] code;
  logic              accept;
  logic              last_idx;
  logic              cfg_hit;

  assign s_ready   = (state_q != ST_HOLD);
  assign accept    = s_valid && s_ready;
  assign last_idx  = (idx_q == IDX_W'(N_FEAT - 1));
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign err_frame = err_q;
  assign cfg_hit   = cfg_we && (cfg_sel != 2'd3) && (int'(cfg_feat) < N_FEAT);

  layer0_feat_quant #(.FEAT_W(FEAT_W)) u_quant (
    .sample_i (s_data),
    .thr0_i   (thr_q[idx_q][0]),
    .thr1_i   (thr_q[idx_q][1]),
    .thr2_i   (thr_q[idx_q][2]),
    .code_o   (code)
  );

  // The quantizer sees the pre-edge threshold, so a same-edge write only
  // affects later samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < N_FEAT; f++) begin
        for (int k = 0; k < N_THR; k++) begin
          thr_q[f][k] <= FEAT_W'(rst_thr(FEAT_W, k));
        end
      end
    end else if (cfg_hit) begin
      thr_q[cfg_feat][cfg_sel] <= cfg_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    err_d     = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          shadow_d[int'(idx_q) * CODE_W +: CODE_W] = code;
          if (!last_idx) begin
            if (s_last) begin
              err_d = 1'b1;
              idx_d = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (s_last) begin
            m_data_d  = shadow_d;
            m_valid_d = 1'b1;
            idx_d     = '0;
            state_d   = ST_HOLD;
          end else begin
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = ST_DISCARD;
          end
        end
      end
      ST_HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_COLLECT;
        end
      end
      ST_DISCARD: begin
        if (accept && s_last) begin
          idx_d   = '0;
          state_d = ST_COLLECT;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_COLLECT;
      idx_q     <= '0;
      shadow_q  <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
    end
  end

`ifdef LN_INPUT_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (m_valid_q && m_ready) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_q)                err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule
